// File: rtl/mips_dmem_bridge_if.sv
// Bus bundle between the CPU data port, the bridge and data memory.
// slave: bridge view. master: environment view (CPU + memory side).
interface mips_dmem_bridge_if;
    // CPU data port
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic        cpu_clk_enable;
    // memory port
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    // sticky error flags
    logic        err_misaligned;
    logic        err_timeout;

    modport slave (
        input  cpu_data_address,
        input  cpu_data_read,
        input  cpu_data_write,
        input  cpu_data_writedata,
        output cpu_data_readdata,
        output cpu_clk_enable,
        output mem_address,
        output mem_read,
        output mem_write,
        output mem_writedata,
        output mem_byteenable,
        input  mem_waitrequest,
        input  mem_readdata,
        output err_misaligned,
        output err_timeout
    );

    modport master (
        output cpu_data_address,
        output cpu_data_read,
        output cpu_data_write,
        output cpu_data_writedata,
        input  cpu_data_readdata,
        input  cpu_clk_enable,
        input  mem_address,
        input  mem_read,
        input  mem_write,
        input  mem_writedata,
        input  mem_byteenable,
        output mem_waitrequest,
        output mem_readdata,
        input  err_misaligned,
        input  err_timeout
    );
endinterface

// File: rtl/mips_dmem_bridge.sv
// Bridges a stalling MIPS data port onto a waitrequest-style memory bus.
// Ports: clk, reset (sync, active-low), bus (mips_dmem_bridge_if.slave).
module mips_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_dmem_bridge_if.slave        bus
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_address;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_writedata;
    logic [3:0]  r_mem_byteenable;
    logic        r_err_misaligned;
    logic        r_err_timeout;

    logic        w_req;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_cke;

    assign w_req        = bus.cpu_data_read | bus.cpu_data_write;
    assign w_misaligned = (bus.cpu_data_address[1:0] != 2'b00);
    // Fires on the busy cycle after LP_TIMEOUT busy cycles were counted.
    assign w_timeout    = (r_cnt == LP_TIMEOUT);

    // Enable must drop in the same cycle a request appears in IDLE.
    always_comb begin
        w_cke = 1'b0;
        case (r_state)
            IDLE:    w_cke = ~w_req;
            DONE:    w_cke = 1'b1;
            default: w_cke = 1'b0;
        endcase
        if (!reset) begin
            w_cke = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_cnt            <= 8'd0;
            r_rdata          <= 32'd0;
            r_mem_address    <= 32'd0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_writedata  <= 32'd0;
            r_mem_byteenable <= 4'd0;
            r_err_misaligned <= 1'b0;
            r_err_timeout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_misaligned) begin
                            r_err_misaligned <= 1'b1;
                            r_rdata          <= 32'd0;
                            r_state          <= DONE;
                        end else begin
                            r_mem_address    <= {bus.cpu_data_address[31:2], 2'b00};
                            r_mem_byteenable <= 4'hF;
                            r_cnt            <= 8'd0;
                            // write wins over a simultaneous read
                            if (bus.cpu_data_write) begin
                                r_mem_writedata <= bus.cpu_data_writedata;
                                r_mem_write     <= 1'b1;
                                r_state         <= WR_WAIT;
                            end else begin
                                r_mem_read <= 1'b1;
                                r_state    <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (!bus.mem_waitrequest) begin
                        r_rdata    <= bus.mem_readdata;
                        r_mem_read <= 1'b0;
                        r_state    <= DONE;
                    end else if (w_timeout) begin
                        r_mem_read    <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_rdata       <= 32'd0;
                        r_state       <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                WR_WAIT: begin
                    if (!bus.mem_waitrequest) begin
                        r_mem_write <= 1'b0;
                        r_state     <= DONE;
                    end else if (w_timeout) begin
                        r_mem_write   <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_rdata       <= 32'd0;
                        r_state       <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_data_readdata = r_rdata;
    assign bus.cpu_clk_enable    = w_cke;
    assign bus.mem_address       = r_mem_address;
    assign bus.mem_read          = r_mem_read;
    assign bus.mem_write         = r_mem_write;
    assign bus.mem_writedata     = r_mem_writedata;
    assign bus.mem_byteenable    = r_mem_byteenable;
    assign bus.err_misaligned    = r_err_misaligned;
    assign bus.err_timeout       = r_err_timeout;

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Directed self-checking bench for mips_dmem_bridge (TIMEOUT_CYCLES=4).
// Ports exercised through one mips_dmem_bridge_if instance.
module tb_mips_dmem_bridge;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mips_dmem_bridge_if bus ();

    mips_dmem_bridge #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.cpu_data_address   = 32'd0;
        bus.cpu_data_read      = 1'b0;
        bus.cpu_data_write     = 1'b0;
        bus.cpu_data_writedata = 32'd0;
        bus.mem_waitrequest    = 1'b0;
        bus.mem_readdata       = 32'd0;

        // reset state
        tick();
        tick();
        chk("rst_rd",   32'(bus.mem_read), 32'd0);
        chk("rst_wr",   32'(bus.mem_write), 32'd0);
        chk("rst_addr", bus.mem_address, 32'd0);
        chk("rst_wd",   bus.mem_writedata, 32'd0);
        chk("rst_be",   32'(bus.mem_byteenable), 32'd0);
        chk("rst_rdat", bus.cpu_data_readdata, 32'd0);
        chk("rst_emis", 32'(bus.err_misaligned), 32'd0);
        chk("rst_eto",  32'(bus.err_timeout), 32'd0);
        chk("rst_cke",  32'(bus.cpu_clk_enable), 32'd0);
        reset = 1'b1;
        #1;
        chk("idle_cke", 32'(bus.cpu_clk_enable), 32'd1);

        // zero-wait read of 0x10
        bus.cpu_data_address = 32'h10;
        bus.cpu_data_read    = 1'b1;
        bus.mem_readdata     = 32'hCAFEF00D;
        #1;
        chk("rd_cke0", 32'(bus.cpu_clk_enable), 32'd0);
        tick();
        chk("rd_strb", 32'(bus.mem_read), 32'd1);
        chk("rd_addr", bus.mem_address, 32'h10);
        chk("rd_be",   32'(bus.mem_byteenable), 32'hF);
        chk("rd_cke1", 32'(bus.cpu_clk_enable), 32'd0);
        tick();
        chk("rd_done_strb", 32'(bus.mem_read), 32'd0);
        chk("rd_cke2", 32'(bus.cpu_clk_enable), 32'd1);
        chk("rd_data", bus.cpu_data_readdata, 32'hCAFEF00D);
        bus.cpu_data_read = 1'b0;
        tick();
        chk("rd_idle_cke", 32'(bus.cpu_clk_enable), 32'd1);
        chk("rd_idle_strb", 32'(bus.mem_read), 32'd0);

        // write 0x20 with 3 busy cycles
        bus.cpu_data_address   = 32'h20;
        bus.cpu_data_write     = 1'b1;
        bus.cpu_data_writedata = 32'h12345678;
        bus.mem_waitrequest    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr_strb", 32'(bus.mem_write), 32'd1);
            chk("wr_addr", bus.mem_address, 32'h20);
            chk("wr_data", bus.mem_writedata, 32'h12345678);
            chk("wr_be",   32'(bus.mem_byteenable), 32'hF);
            chk("wr_cke",  32'(bus.cpu_clk_enable), 32'd0);
            bus.cpu_data_writedata = 32'hDEADBEEF;
            bus.cpu_data_address   = 32'h24;
            if (i == 3) bus.mem_waitrequest = 1'b0;
        end
        tick();
        chk("wr_done_strb", 32'(bus.mem_write), 32'd0);
        chk("wr_done_cke",  32'(bus.cpu_clk_enable), 32'd1);
        chk("wr_no_eto",    32'(bus.err_timeout), 32'd0);
        bus.cpu_data_write = 1'b0;
        tick();
        chk("wr_idle_cke", 32'(bus.cpu_clk_enable), 32'd1);
        chk("wr_idle_strb", 32'(bus.mem_write), 32'd0);

        // misaligned read of 0x06
        bus.cpu_data_address = 32'h6;
        bus.cpu_data_read    = 1'b1;
        bus.mem_readdata     = 32'h77777777;
        #1;
        chk("mis_cke0", 32'(bus.cpu_clk_enable), 32'd0);
        tick();
        chk("mis_rd",   32'(bus.mem_read), 32'd0);
        chk("mis_wr",   32'(bus.mem_write), 32'd0);
        chk("mis_flag", 32'(bus.err_misaligned), 32'd1);
        chk("mis_rdat", bus.cpu_data_readdata, 32'd0);
        chk("mis_cke1", 32'(bus.cpu_clk_enable), 32'd1);
        bus.cpu_data_read = 1'b0;
        tick();
        chk("mis_idle_rd", 32'(bus.mem_read), 32'd0);
        // good read afterwards keeps the flag
        bus.cpu_data_address = 32'h40;
        bus.cpu_data_read    = 1'b1;
        bus.mem_readdata     = 32'h11112222;
        tick();
        chk("good_strb", 32'(bus.mem_read), 32'd1);
        tick();
        chk("good_data", bus.cpu_data_readdata, 32'h11112222);
        chk("mis_sticky", 32'(bus.err_misaligned), 32'd1);
        bus.cpu_data_read = 1'b0;
        tick();

        // timeout read: 4 tolerated busy cycles, dropped on the 5th
        bus.cpu_data_address = 32'h80;
        bus.cpu_data_read    = 1'b1;
        bus.mem_waitrequest  = 1'b1;
        bus.mem_readdata     = 32'h55555555;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("to_strb", 32'(bus.mem_read), 32'd1);
            chk("to_addr", bus.mem_address, 32'h80);
            chk("to_cke",  32'(bus.cpu_clk_enable), 32'd0);
            bus.cpu_data_address = 32'h9C;
        end
        tick();
        chk("to_drop", 32'(bus.mem_read), 32'd0);
        chk("to_flag", 32'(bus.err_timeout), 32'd1);
        chk("to_rdat", bus.cpu_data_readdata, 32'd0);
        chk("to_cke1", 32'(bus.cpu_clk_enable), 32'd1);
        bus.cpu_data_read   = 1'b0;
        bus.mem_waitrequest = 1'b0;
        tick();
        chk("to_idle_cke", 32'(bus.cpu_clk_enable), 32'd1);
        chk("to_sticky", 32'(bus.err_timeout), 32'd1);

        // read + write together: write only
        bus.cpu_data_address   = 32'h30;
        bus.cpu_data_read      = 1'b1;
        bus.cpu_data_write     = 1'b1;
        bus.cpu_data_writedata = 32'hA5A5A5A5;
        tick();
        chk("rw_wr",   32'(bus.mem_write), 32'd1);
        chk("rw_rd",   32'(bus.mem_read), 32'd0);
        chk("rw_data", bus.mem_writedata, 32'hA5A5A5A5);
        tick();
        chk("rw_done_cke", 32'(bus.cpu_clk_enable), 32'd1);
        bus.cpu_data_read  = 1'b0;
        bus.cpu_data_write = 1'b0;
        tick();

        // reset during WR_WAIT
        bus.cpu_data_address   = 32'h44;
        bus.cpu_data_write     = 1'b1;
        bus.cpu_data_writedata = 32'h0BADF00D;
        bus.mem_waitrequest    = 1'b1;
        tick();
        chk("rw2_wr", 32'(bus.mem_write), 32'd1);
        reset = 1'b0;
        tick();
        chk("mrst_wr",   32'(bus.mem_write), 32'd0);
        chk("mrst_emis", 32'(bus.err_misaligned), 32'd0);
        chk("mrst_eto",  32'(bus.err_timeout), 32'd0);
        chk("mrst_cke",  32'(bus.cpu_clk_enable), 32'd0);
        reset = 1'b1;
        bus.cpu_data_write  = 1'b0;
        bus.mem_waitrequest = 1'b0;
        #1;
        chk("mrst_idle_cke", 32'(bus.cpu_clk_enable), 32'd1);
        tick();
        chk("mrst_idle_wr", 32'(bus.mem_write), 32'd0);
        chk("mrst_idle_rd", 32'(bus.mem_read), 32'd0);
        chk("mrst_idle_cke2", 32'(bus.cpu_clk_enable), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
